branch_update_queue: RTL and testbench
======================================

Name: branch_update_queue

Overview:
- In-order tracker for predicted conditional branches, between fetch/issue and the branch history table.
- Records each predicted branch at issue, accepts out-of-order resolutions from the branch ALU, and retires entries in program order.
- On each retirement it produces one BHT update (right/wrong + index) and, on a mispredict, a redirect pulse with a full queue clear.
- It is the update-writing end of the BHT interface: the BHT reads predictions, this block trains it.

Parameters:
- DEPTH_LOG, 4, log2 of entry count (DEPTH = 16)
- PC_W, 32, width of branch PC and target

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- flush  in  1  external pipeline flush; clears queue
- alloc_valid  in  1  record a new predicted branch this cycle
- alloc_pc  in  PC_W  branch PC
- alloc_pred  in  1  predicted taken
- alloc_tag  out  DEPTH_LOG  tag assigned to an accepted alloc (current tail pointer, combinational)
- full  out  1  count == DEPTH; alloc ignored
- resolve_valid  in  1  branch outcome available
- resolve_tag  in  DEPTH_LOG  tag of resolved branch
- resolve_taken  in  1  actual direction
- resolve_target  in  PC_W  correct next PC
- upd_right  out  1  registered pulse: retired prediction correct
- upd_wrong  out  1  registered pulse: retired prediction wrong
- upd_index  out  PC_W  PC of retired branch (BHT uses [11:0])
- mispredict  out  1  registered pulse, same cycle as upd_wrong
- redirect_pc  out  PC_W  resolve_target of mispredicted branch, valid with mispredict

Behaviour:
- Storage per slot: valid, pc, pred, resolved, taken, target. Slots are addressed by head/tail pointers mod DEPTH, with count 0..DEPTH.
- Reset: all valid = 0, head = tail = count = 0. upd_right, upd_wrong and mispredict are 0; upd_index and redirect_pc are 0.
- rdy low: no state changes. upd_right, upd_wrong and mispredict are forced to 0 at that edge, so each update is emitted exactly once.
- Priority at each edge with rdy high: rst > flush > retire-mispredict clear > normal operation.
- flush: all slots invalid, pointers and count 0, no update pulses issued. A resolve or alloc in the same cycle is dropped.
- Alloc: accepted when alloc_valid && !full. The slot at tail gets valid = 1, resolved = 0 and the pc/pred fields; tail++, count++.
- Alloc while full: ignored, no state change.
- Resolve: when resolve_valid, the slot at resolve_tag is valid and not yet resolved, set resolved = 1 and store taken/target.
- Resolve to an invalid or already-resolved slot: ignored.
- Retire condition: the head slot is valid and resolved. At most one retirement per cycle, evaluated on registered state only. A resolve at edge N therefore retires at edge N+1 at the earliest, and the pulses are visible during the cycle after N+1.
- Retire correct (taken == pred):
  - upd_right = 1 and upd_index = pc.
  - head++, count--.
- Retire wrong:
  - upd_wrong = 1, mispredict = 1, upd_index = pc, redirect_pc = target.
  - All slots are cleared (every younger entry is wrong-path); pointers and count go to 0.
  - An alloc in the same cycle is dropped.
- Simultaneous alloc and correct retire: both happen, count unchanged. An alloc is accepted when count == DEPTH and a retire happens in the same cycle? No: full is evaluated on the pre-edge count, so the alloc is rejected.
- Pointer wrap: tail/head roll over from DEPTH-1 to 0. Tags are reused only after the slot has been retired or cleared.
- Pulse outputs are high for exactly one cycle per retirement. upd_index and redirect_pc hold their last value otherwise.

Optional Feature:
- Macro BUQ_STATS_EN.
- Defined: two extra outputs, stat_branches [31:0] and stat_mispred [31:0].
  - stat_branches increments on every retirement; stat_mispred increments on every upd_wrong.
  - Both are reset to 0 by rst only, frozen when rdy is low, wrap at 2^32.
- Undefined: both ports exist and are tied to 0; no counter logic.

Test Plan:
- Reset, then alloc pc=0x100 pred=1, resolve tag 0 taken=1 -> two cycles later upd_right=1, upd_index=0x100, count 0; no mispredict.
- Alloc 0x200 (pred 0) and 0x204 (pred 1); resolve tag 1 first, then tag 0 taken=1 target=0x300 -> tag 0 retires with upd_wrong=1, mispredict=1, redirect_pc=0x300; tag 1 is discarded and never emits an update.
- Alloc 16 branches -> full=1; 17th alloc ignored; resolve and retire one correct -> full=0; next alloc gets tag 0 (wrap).
- Resolve head while rdy=0 for 3 cycles -> no pulses; rdy returns -> exactly one upd_right.
- flush asserted with 5 resolved entries -> no update pulses, count 0, next alloc_tag=0.
- Retire-wrong cycle coinciding with alloc_valid pc=0x400 -> alloc dropped, queue empty afterwards; with BUQ_STATS_EN, stat_mispred increments by 1.

Source files
------------

// File: rtl/branch_update_queue.sv
// branch_update_queue: in-order predicted-branch tracker that trains the BHT on retirement (optional BUQ_STATS_EN counters).
module branch_update_queue #(
  parameter int DEPTH_LOG = 4,
  parameter int PC_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 alloc_valid,
  input  logic [PC_W-1:0]      alloc_pc,
  input  logic                 alloc_pred,
  output logic [DEPTH_LOG-1:0] alloc_tag,
  output logic                 full,
  input  logic                 resolve_valid,
  input  logic [DEPTH_LOG-1:0] resolve_tag,
  input  logic                 resolve_taken,
  input  logic [PC_W-1:0]      resolve_target,
  output logic                 upd_right,
  output logic                 upd_wrong,
  output logic [PC_W-1:0]      upd_index,
  output logic                 mispredict,
  output logic [PC_W-1:0]      redirect_pc,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispred
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  logic [DEPTH-1:0] valid_q, valid_d, res_q, res_d, pred_q, pred_d, taken_q, taken_d;
  logic [PC_W-1:0] pc_q [DEPTH];
  logic [PC_W-1:0] pc_d [DEPTH];
  logic [PC_W-1:0] tgt_q [DEPTH];
  logic [PC_W-1:0] tgt_d [DEPTH];
  logic [DEPTH_LOG-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH_LOG:0] count_q, count_d;
  logic upd_right_q, upd_right_d, upd_wrong_q, upd_wrong_d;
  logic [PC_W-1:0] upd_index_q, upd_index_d, redirect_q, redirect_d;
  logic head_done, ret_ok, ret_bad, do_res, do_alloc;
  assign full = count_q[DEPTH_LOG];
  assign alloc_tag = tail_q;
  assign upd_right = upd_right_q;
  assign upd_wrong = upd_wrong_q;
  assign mispredict = upd_wrong_q;
  assign upd_index = upd_index_q;
  assign redirect_pc = redirect_q;
  // Retirement looks only at registered state, so a fresh resolve waits one edge.
  assign head_done = valid_q[head_q] & res_q[head_q];
  assign ret_bad = head_done & (taken_q[head_q] != pred_q[head_q]);
  assign ret_ok = head_done & ~ret_bad;
  assign do_res = resolve_valid & valid_q[resolve_tag] & ~res_q[resolve_tag];
  assign do_alloc = alloc_valid & ~full;
  always_comb begin
    valid_d = valid_q;
    res_d = res_q;
    pred_d = pred_q;
    taken_d = taken_q;
    pc_d = pc_q;
    tgt_d = tgt_q;
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    upd_right_d = 1'b0;
    upd_wrong_d = 1'b0;
    upd_index_d = upd_index_q;
    redirect_d = redirect_q;
    if (rdy && (flush || ret_bad)) begin
      valid_d = '0;
      head_d = '0;
      tail_d = '0;
      count_d = '0;
      upd_wrong_d = !flush;
      upd_index_d = flush ? upd_index_q : pc_q[head_q];
      redirect_d = flush ? redirect_q : tgt_q[head_q];
    end else if (rdy) begin
      if (do_res) begin
        res_d[resolve_tag] = 1'b1;
        taken_d[resolve_tag] = resolve_taken;
        tgt_d[resolve_tag] = resolve_target;
      end
      if (ret_ok) begin
        upd_right_d = 1'b1;
        upd_index_d = pc_q[head_q];
        valid_d[head_q] = 1'b0;
        head_d = head_q + DEPTH_LOG'(1);
      end
      if (do_alloc) begin
        valid_d[tail_q] = 1'b1;
        res_d[tail_q] = 1'b0;
        pc_d[tail_q] = alloc_pc;
        pred_d[tail_q] = alloc_pred;
        tail_d = tail_q + DEPTH_LOG'(1);
      end
      count_d = count_q + (DEPTH_LOG+1)'(do_alloc) - (DEPTH_LOG+1)'(ret_ok);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      res_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      upd_right_q <= 1'b0;
      upd_wrong_q <= 1'b0;
      upd_index_q <= '0;
      redirect_q <= '0;
    end else begin
      valid_q <= valid_d;
      res_q <= res_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      upd_right_q <= upd_right_d;
      upd_wrong_q <= upd_wrong_d;
      upd_index_q <= upd_index_d;
      redirect_q <= redirect_d;
    end
  end
  always_ff @(posedge clk) begin
    pred_q <= pred_d;
    taken_q <= taken_d;
    pc_q <= pc_d;
    tgt_q <= tgt_d;
  end
`ifdef BUQ_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d, stat_mispred_q, stat_mispred_d;
  always_comb begin
    stat_branches_d = stat_branches_q + 32'(upd_right_d | upd_wrong_d);
    stat_mispred_d = stat_mispred_q + 32'(upd_wrong_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end
  assign stat_branches = stat_branches_q;
  assign stat_mispred = stat_mispred_q;
`else
  assign stat_branches = '0;
  assign stat_mispred = '0;
`endif
endmodule

// File: tb/tb_branch_update_queue.sv
// tb_branch_update_queue: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_branch_update_queue;
  logic clk = 1'b0;
  logic rst, rdy, flush, alloc_valid, alloc_pred, resolve_valid, resolve_taken;
  logic [31:0] alloc_pc, resolve_target;
  logic [3:0] alloc_tag, resolve_tag;
  logic full, upd_right, upd_wrong, mispredict;
  logic [31:0] upd_index, redirect_pc, stat_branches, stat_mispred;
  int n_tests = 0;
  int n_fail = 0;

  branch_update_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
    .alloc_tag(alloc_tag), .full(full),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .upd_right(upd_right), .upd_wrong(upd_wrong), .upd_index(upd_index),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic pred;
    logic res;
    logic tk;
    logic [31:0] tgt;
  } ent_t;
  ent_t mq[$];
  int mh;
  logic e_r, e_w;
  logic [31:0] e_idx, e_rd, m_br, m_mp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1;
    flush = 1'b0;
    alloc_valid = 1'b0;
    alloc_pc = '0;
    alloc_pred = 1'b0;
    resolve_valid = 1'b0;
    resolve_tag = '0;
    resolve_taken = 1'b0;
    resolve_target = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic pred);
    idle();
    alloc_valid = 1'b1;
    alloc_pc = pc;
    alloc_pred = pred;
    tick();
  endtask

  task automatic resolve(input logic [3:0] tag, input logic tk, input logic [31:0] tgt);
    idle();
    resolve_valid = 1'b1;
    resolve_tag = tag;
    resolve_taken = tk;
    resolve_target = tgt;
    tick();
  endtask

  // Reference model: one edge of behaviour on the current inputs.
  task automatic model_step();
    int n, off;
    logic ret;
    ent_t e;
    e_r = 1'b0;
    e_w = 1'b0;
    if (!rdy) return;
    if (flush) begin
      mq.delete();
      mh = 0;
      return;
    end
    n = mq.size();
    ret = n > 0 && mq[0].res;
    if (ret && mq[0].tk != mq[0].pred) begin
      e_w = 1'b1;
      e_idx = mq[0].pc;
      e_rd = mq[0].tgt;
      mq.delete();
      mh = 0;
      m_br++;
      m_mp++;
      return;
    end
    if (resolve_valid) begin
      off = (int'(resolve_tag) - mh + 16) % 16;
      if (off < n && !mq[off].res) begin
        mq[off].res = 1'b1;
        mq[off].tk = resolve_taken;
        mq[off].tgt = resolve_target;
      end
    end
    if (alloc_valid && n < 16) begin
      e.pc = alloc_pc;
      e.pred = alloc_pred;
      e.res = 1'b0;
      e.tk = 1'b0;
      e.tgt = '0;
      mq.push_back(e);
    end
    if (ret) begin
      e_r = 1'b1;
      e_idx = mq[0].pc;
      void'(mq.pop_front());
      mh = (mh + 1) % 16;
      m_br++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({upd_right, upd_wrong, mispredict, full} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b want 0000", {upd_right, upd_wrong, mispredict, full});
    end
    n_tests++;
    if ({upd_index, redirect_pc, alloc_tag} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_data: got idx=%h rd=%h tag=%0d want 0", upd_index, redirect_pc, alloc_tag);
    end
    n_tests++;
    if ({stat_branches, stat_mispred} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_stats: got %h %h want 0", stat_branches, stat_mispred);
    end
  endtask

  task automatic test_correct();
    do_reset();
    alloc(32'h100, 1'b1);
    resolve(4'd0, 1'b1, 32'h104);
    n_tests++;
    if (upd_right !== 1'b0) begin
      n_fail++;
      $display("FAIL correct_early: got upd_right=%b want 0", upd_right);
    end
    idle();
    tick();
    n_tests++;
    if ({upd_right, upd_wrong, mispredict} !== 3'b100 || upd_index !== 32'h100) begin
      n_fail++;
      $display("FAIL correct_retire: got r/w/m=%b idx=%h want 100 idx=100", {upd_right, upd_wrong, mispredict}, upd_index);
    end
    tick();
    n_tests++;
    if (upd_right !== 1'b0 || upd_index !== 32'h100 || alloc_tag !== 4'd1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL correct_after: got r=%b idx=%h tag=%0d full=%b want 0 100 1 0", upd_right, upd_index, alloc_tag, full);
    end
  endtask

  task automatic test_mispredict();
    logic extra;
    do_reset();
    alloc(32'h200, 1'b0);
    alloc(32'h204, 1'b1);
    resolve(4'd1, 1'b1, 32'h208);
    resolve(4'd0, 1'b1, 32'h300);
    idle();
    tick();
    n_tests++;
    if ({upd_right, upd_wrong, mispredict} !== 3'b011 || upd_index !== 32'h200 || redirect_pc !== 32'h300) begin
      n_fail++;
      $display("FAIL mispredict_retire: got r/w/m=%b idx=%h rd=%h want 011 200 300", {upd_right, upd_wrong, mispredict}, upd_index, redirect_pc);
    end
    extra = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      extra |= upd_right | upd_wrong | mispredict;
    end
    n_tests++;
    if (extra !== 1'b0 || alloc_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL mispredict_discard: got extra=%b tag=%0d want 0 0", extra, alloc_tag);
    end
  endtask

  task automatic test_full();
    logic bad_tag;
    do_reset();
    bad_tag = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bad_tag |= alloc_tag !== 4'(i);
      alloc(32'h1000 + 32'(i * 4), 1'(i));
    end
    n_tests++;
    if (bad_tag !== 1'b0 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_fill: got badtag=%b full=%b want 0 1", bad_tag, full);
    end
    alloc(32'hdead, 1'b1);
    n_tests++;
    if (full !== 1'b1 || alloc_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL full_ignore: got full=%b tag=%0d want 1 0", full, alloc_tag);
    end
    resolve(4'd0, 1'b0, 32'h0);
    idle();
    tick();
    n_tests++;
    if (upd_right !== 1'b1 || upd_index !== 32'h1000 || full !== 1'b0 || alloc_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL full_wrap: got r=%b idx=%h full=%b tag=%0d want 1 1000 0 0", upd_right, upd_index, full, alloc_tag);
    end
    alloc(32'h2000, 1'b0);
    n_tests++;
    if (full !== 1'b1 || alloc_tag !== 4'd1) begin
      n_fail++;
      $display("FAIL full_refill: got full=%b tag=%0d want 1 1", full, alloc_tag);
    end
  endtask

  task automatic test_rdy();
    logic any;
    do_reset();
    alloc(32'h700, 1'b0);
    resolve(4'd0, 1'b0, 32'h0);
    idle();
    rdy = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      any |= upd_right | upd_wrong;
    end
    n_tests++;
    if (any !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_frozen: got pulse=%b want 0", any);
    end
    rdy = 1'b1;
    tick();
    n_tests++;
    if (upd_right !== 1'b1 || upd_index !== 32'h700) begin
      n_fail++;
      $display("FAIL rdy_release: got r=%b idx=%h want 1 700", upd_right, upd_index);
    end
    tick();
    n_tests++;
    if (upd_right !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_once: got r=%b want 0", upd_right);
    end
  endtask

  task automatic test_flush();
    logic any;
    do_reset();
    for (int i = 0; i < 6; i++) alloc(32'h800 + 32'(i * 4), 1'b1);
    for (int i = 1; i < 6; i++) resolve(4'(i), 1'b1, 32'h0);
    idle();
    flush = 1'b1;
    resolve_valid = 1'b1;
    resolve_tag = 4'd0;
    resolve_taken = 1'b1;
    tick();
    any = upd_right | upd_wrong | mispredict;
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      any |= upd_right | upd_wrong | mispredict;
    end
    n_tests++;
    if (any !== 1'b0 || alloc_tag !== 4'd0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear: got pulse=%b tag=%0d full=%b want 0 0 0", any, alloc_tag, full);
    end
  endtask

  task automatic test_wrong_alloc();
    logic [31:0] want;
    do_reset();
    alloc(32'h500, 1'b0);
    resolve(4'd0, 1'b1, 32'h600);
    idle();
    alloc_valid = 1'b1;
    alloc_pc = 32'h400;
    alloc_pred = 1'b1;
    tick();
    n_tests++;
    if (upd_wrong !== 1'b1 || redirect_pc !== 32'h600 || alloc_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL wrong_alloc: got w=%b rd=%h tag=%0d want 1 600 0", upd_wrong, redirect_pc, alloc_tag);
    end
`ifdef BUQ_STATS_EN
    want = 32'd1;
`else
    want = 32'd0;
`endif
    n_tests++;
    if (stat_mispred !== want || stat_branches !== want) begin
      n_fail++;
      $display("FAIL wrong_alloc_stats: got mp=%0d br=%0d want %0d", stat_mispred, stat_branches, want);
    end
  endtask

  task automatic test_random();
    int off, errs;
    logic [3:0] e_tag;
    do_reset();
    mq.delete();
    mh = 0;
    e_idx = '0;
    e_rd = '0;
    m_br = '0;
    m_mp = '0;
    errs = 0;
    for (int c = 0; c < 3000; c++) begin
      idle();
      rdy = ($urandom % 10) != 0;
      flush = ($urandom % 150) == 0;
      alloc_valid = ($urandom % 3) != 0;
      alloc_pc = $urandom;
      alloc_pred = 1'($urandom);
      resolve_valid = ($urandom % 2) != 0;
      off = mq.size() > 0 && ($urandom % 8) != 0 ? int'($urandom_range(0, mq.size() - 1)) : int'($urandom % 16);
      resolve_tag = 4'((mh + off) % 16);
      resolve_taken = off < mq.size() && ($urandom % 25) != 0 ? mq[off].pred : 1'($urandom);
      resolve_target = $urandom;
      model_step();
      tick();
      e_tag = 4'((mh + mq.size()) % 16);
      n_tests++;
      if (upd_right !== e_r || upd_wrong !== e_w || mispredict !== e_w || upd_index !== e_idx
          || redirect_pc !== e_rd || full !== (mq.size() == 16) || alloc_tag !== e_tag) begin
        n_fail++;
        errs++;
        if (errs < 10)
          $display("FAIL random_c%0d: got r/w/m=%b%b%b idx=%h rd=%h full=%b tag=%0d want %b%b%b %h %h %b %0d",
                   c, upd_right, upd_wrong, mispredict, upd_index, redirect_pc, full, alloc_tag,
                   e_r, e_w, e_w, e_idx, e_rd, mq.size() == 16, e_tag);
      end
    end
`ifndef BUQ_STATS_EN
    m_br = '0;
    m_mp = '0;
`endif
    n_tests++;
    if (stat_branches !== m_br || stat_mispred !== m_mp) begin
      n_fail++;
      $display("FAIL random_stats: got br=%0d mp=%0d want %0d %0d", stat_branches, stat_mispred, m_br, m_mp);
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_mispredict();
    test_full();
    test_rdy();
    test_flush();
    test_wrong_alloc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
